// File: rtl/display_mux_7seg_pkg.sv
// Shared definitions for the multiplexed 4-digit 7-segment display driver:
// glyph constants (active-high, bit0=a .. bit6=g), digit index type and
// prescaler width helper.
package display_mux_7seg_pkg;

    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [3:0]       digit_t;
    typedef logic [6:0]       glyph_t;

    localparam glyph_t SEG_0    = 7'h3F;
    localparam glyph_t SEG_1    = 7'h06;
    localparam glyph_t SEG_2    = 7'h5B;
    localparam glyph_t SEG_3    = 7'h4F;
    localparam glyph_t SEG_4    = 7'h66;
    localparam glyph_t SEG_5    = 7'h6D;
    localparam glyph_t SEG_6    = 7'h7D;
    localparam glyph_t SEG_7    = 7'h07;
    localparam glyph_t SEG_8    = 7'h7F;
    localparam glyph_t SEG_9    = 7'h6F;
    localparam glyph_t SEG_DASH = 7'h40;
    localparam glyph_t SEG_OFF  = 7'h00;

    // Bits needed to count 0 .. div-1 (never less than one bit).
    function automatic int tick_width(input int div);
        int w;
        w = $clog2(div);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/display_mux_7seg_seg7_decode.sv
// Combinational BCD to 7-segment decoder, active-high segments.
// Non-BCD codes (A-F) show a lone dash as an error glyph.
module seg7_decode
    import display_mux_7seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    // Map one digit code to its active-high segment pattern.
    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_mux_7seg.sv
// Time-multiplexed common-anode 4-digit 7-segment driver. A prescaler splits
// time into digit slots; all four digits are snapshotted at the start of
// slot 0 so a scan never mixes old and new values. Each slot begins with a
// short dark guard interval to suppress ghosting between digits.
module display_mux_7seg
    import display_mux_7seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena_disp,
    input  logic [3:0] Qdata3,
    input  logic [3:0] Qdata2,
    input  logic [3:0] Qdata1,
    input  logic [3:0] Qdata0,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic [1:0] digit_sel
);

    localparam int                TICK_W   = tick_width(REFRESH_DIV);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(REFRESH_DIV - 1);
    localparam logic [TICK_W-1:0] GUARD_T  = TICK_W'(GUARD);
    localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
    localparam logic [3:0]        AN_OFF   = AN_ACT_LOW  ? 4'hF  : 4'h0;
    localparam logic [6:0]        SEG_DARK = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = SEG_ACT_LOW ? 1'b1  : 1'b0;

    logic [TICK_W-1:0] tick_q, tick_d;
    idx_t              idx_q, idx_d;
    logic [3:0][3:0]   snap_q, snap_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [1:0]        sel_q, sel_d;
    logic              dp_q;

    logic [3:0]        cur_digit_s;
    logic [6:0]        glyph_s;
    logic              blank_s;
    logic [3:0]        an_onehot_s;

    // Prescaler, slot sequencer and start-of-scan snapshot.
    always_comb begin
        tick_d = tick_q;
        idx_d  = idx_q;
        snap_d = snap_q;
        if (ena_disp) begin
            if ((tick_q == '0) && (idx_q == '0)) begin
                snap_d = {Qdata3, Qdata2, Qdata1, Qdata0};
            end else begin
                snap_d = snap_q;
            end
            if (tick_q == TICK_MAX) begin
                tick_d = '0;
                idx_d  = idx_q + 2'd1;
            end else begin
                tick_d = tick_q + TICK_ONE;
                idx_d  = idx_q;
            end
        end else begin
            tick_d = tick_q;
            idx_d  = idx_q;
            snap_d = snap_q;
        end
    end

    // The slot-0 start cycle must already see the freshly latched digits.
    assign cur_digit_s = snap_d[idx_q];

    seg7_decode u_decode (
        .digit_i (cur_digit_s),
        .seg_o   (glyph_s)
    );

    // Leading-zero blanking; non-BCD codes count as non-zero.
    always_comb begin
        blank_s = 1'b0;
        case (idx_q)
            2'd3:    blank_s = (snap_d[3] == 4'd0);
            2'd2:    blank_s = (snap_d[3] == 4'd0) && (snap_d[2] == 4'd0);
            2'd1:    blank_s = (snap_d[3] == 4'd0) && (snap_d[2] == 4'd0)
                               && (snap_d[1] == 4'd0);
            default: blank_s = 1'b0;
        endcase
        if (!BLANK_LZ) begin
            blank_s = 1'b0;
        end else begin
            blank_s = blank_s;
        end
    end

    assign an_onehot_s = 4'b0001 << idx_q;

    // Next output values: dark during guard, blank or disable, else lit digit.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_DARK;
        sel_d = idx_q;
        if (ena_disp && (tick_q >= GUARD_T) && !blank_s) begin
            an_d  = AN_ACT_LOW  ? ~an_onehot_s : an_onehot_s;
            seg_d = SEG_ACT_LOW ? ~glyph_s     : glyph_s;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_DARK;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_DARK;
            sel_q  <= 2'd0;
            dp_q   <= DP_OFF;
        end else begin
            tick_q <= tick_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            sel_q  <= sel_d;
            dp_q   <= DP_OFF;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Directed bench for display_mux_7seg with REFRESH_DIV=4, GUARD=1 and
// active-low outputs: each slot is one dark guard cycle then three lit cycles.
module tb_display_mux_7seg;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena_disp;
    logic [3:0] Qdata3, Qdata2, Qdata1, Qdata0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] digit_sel;

    int checks_cnt = 0;
    int errors_cnt = 0;

    display_mux_7seg #(
        .REFRESH_DIV (4),
        .GUARD       (1),
        .SEG_ACT_LOW (1'b1),
        .AN_ACT_LOW  (1'b1),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena_disp  (ena_disp),
        .Qdata3    (Qdata3),
        .Qdata2    (Qdata2),
        .Qdata1    (Qdata1),
        .Qdata0    (Qdata0),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .digit_sel (digit_sel)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] an_e,
                             input logic [6:0] seg_e, input logic [1:0] sel_e);
        check_eq({tag, "_an"},  {28'd0, an},        {28'd0, an_e});
        check_eq({tag, "_seg"}, {25'd0, seg},       {25'd0, seg_e});
        check_eq({tag, "_sel"}, {30'd0, digit_sel}, {30'd0, sel_e});
    endtask

    // One full slot: guard cycle dark, then three lit (or blank) cycles.
    task automatic check_slot(input string tag, input logic [1:0] d,
                              input logic [3:0] an_e, input logic [6:0] seg_e);
        step();
        check_out({tag, "_guard"}, 4'hF, 7'h7F, d);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out({tag, "_act"}, an_e, seg_e, d);
        end
    endtask

    initial begin
        rst = 1'b1; ena_disp = 1'b0;
        Qdata3 = 4'd0; Qdata2 = 4'd0; Qdata1 = 4'd0; Qdata0 = 4'd0;

        // 1: reset state held
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("rst", 4'hF, 7'h7F, 2'd0);
            check_eq("rst_dp", {31'd0, dp}, 32'd1);
        end

        // 2: digits 9,7,6,5 (d3..d0)
        Qdata3 = 4'd9; Qdata2 = 4'd7; Qdata1 = 4'd6; Qdata0 = 4'd5;
        rst = 1'b0; ena_disp = 1'b1;
        check_slot("t2_d0", 2'd0, 4'hE, 7'h12);
        check_slot("t2_d1", 2'd1, 4'hD, 7'h02);
        check_slot("t2_d2", 2'd2, 4'hB, 7'h78);
        check_slot("t2_d3", 2'd3, 4'h7, 7'h10);
        check_eq("t2_dp", {31'd0, dp}, 32'd1);

        // 3: leading zeros blanked on digits 3 and 2
        Qdata3 = 4'd0; Qdata2 = 4'd0; Qdata1 = 4'd4; Qdata0 = 4'd0;
        check_slot("t3_d0", 2'd0, 4'hE, 7'h40);
        check_slot("t3_d1", 2'd1, 4'hD, 7'h19);
        check_slot("t3_d2", 2'd2, 4'hF, 7'h7F);
        check_slot("t3_d3", 2'd3, 4'hF, 7'h7F);

        // 4: inputs change while idx=2; old snapshot kept until next scan
        check_slot("t4_d0", 2'd0, 4'hE, 7'h40);
        check_slot("t4_d1", 2'd1, 4'hD, 7'h19);
        Qdata3 = 4'd1; Qdata2 = 4'd2; Qdata1 = 4'd3; Qdata0 = 4'd4;
        check_slot("t4_d2_old", 2'd2, 4'hF, 7'h7F);
        check_slot("t4_d3_old", 2'd3, 4'hF, 7'h7F);
        check_slot("t4_d0_new", 2'd0, 4'hE, 7'h19);

        // 5: disable at tick 2 of slot 1 for 5 cycles, then resume
        step();
        check_out("t5_guard", 4'hF, 7'h7F, 2'd1);
        step();
        check_out("t5_act0", 4'hD, 7'h30, 2'd1);
        ena_disp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out("t5_off", 4'hF, 7'h7F, 2'd1);
        end
        ena_disp = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_out("t5_resume", 4'hD, 7'h30, 2'd1);
        end
        check_slot("t5_d2", 2'd2, 4'hB, 7'h24);
        check_slot("t5_d3", 2'd3, 4'h7, 7'h79);

        // 6: non-BCD digit shows dash; reset in the middle of slot 3
        Qdata0 = 4'hC;
        check_slot("t6_d0", 2'd0, 4'hE, 7'h3F);
        check_slot("t6_d1", 2'd1, 4'hD, 7'h30);
        check_slot("t6_d2", 2'd2, 4'hB, 7'h24);
        step();
        check_out("t6_d3_guard", 4'hF, 7'h7F, 2'd3);
        step();
        check_out("t6_d3_act", 4'h7, 7'h79, 2'd3);
        rst = 1'b1;
        step();
        check_out("t6_rst", 4'hF, 7'h7F, 2'd0);
        check_eq("t6_rst_dp", {31'd0, dp}, 32'd1);
        step();
        check_out("t6_rst_hold", 4'hF, 7'h7F, 2'd0);
        rst = 1'b0;
        check_slot("t6_restart_d0", 2'd0, 4'hE, 7'h3F);
        check_slot("t6_restart_d1", 2'd1, 4'hD, 7'h30);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
